// File: rtl/reg_bank4_pkg.sv
// Shared constants and the one-hot select legality check for the 4-entry register bank.
package reg_bank4_pkg;

  localparam int unsigned NUM_ENTRIES = 4;
  localparam int unsigned ADDR_W      = 2;

  // A select is legal only when exactly one strobe is set.
  function automatic logic is_one_hot(input logic [NUM_ENTRIES-1:0] sel);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (sel[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/reg_bank4_entry.sv
// One storage entry: a W-bit data register plus a valid bit.
module reg_bank4_entry #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      if (we) q <= d;
      // A write in the same cycle as a clear leaves this entry valid.
      if (we)       valid <= 1'b1;
      else if (clr) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_bank4.sv
// Four-entry write-enabled register bank fed by one-hot decoder strobes, with a registered read port.
module reg_bank4
  import reg_bank4_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_WEN,
  input  logic              io_CTRL_0,
  input  logic              io_CTRL_1,
  input  logic              io_CTRL_2,
  input  logic              io_CTRL_3,
  input  logic [W-1:0]      io_WDATA,
  input  logic              io_CLR,
  input  logic [ADDR_W-1:0] io_RADD,
  output logic [W-1:0]      io_RDATA,
  output logic              io_RVALID,
  output logic              io_ERR
);

  logic [NUM_ENTRIES-1:0] ctrl;
  logic                   wr_legal;
  logic                   wr_illegal;
  logic [NUM_ENTRIES-1:0] ent_we;
  logic [W-1:0]           ent_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] ent_v;
  logic                   bypass;
  logic [W-1:0]           rd_data_nxt;
  logic                   rd_valid_nxt;

  assign ctrl = {io_CTRL_3, io_CTRL_2, io_CTRL_1, io_CTRL_0};

  always_comb begin
    wr_legal   = 1'b0;
    wr_illegal = 1'b0;
    if (io_WEN) begin
      wr_legal   = is_one_hot(ctrl);
      wr_illegal = !wr_legal;
    end
  end

  assign ent_we = wr_legal ? ctrl : '0;

  for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_entry
    reg_bank4_entry #(.W(W)) u_entry (
      .clk   (clk),
      .reset (reset),
      .we    (ent_we[k]),
      .clr   (io_CLR),
      .d     (io_WDATA),
      .q     (ent_q[k]),
      .valid (ent_v[k])
    );
  end

  // Bypass forwards a same-cycle write; otherwise a concurrent clear is seen before the read.
  always_comb begin
    bypass       = wr_legal && ctrl[io_RADD];
    rd_data_nxt  = ent_q[io_RADD];
    rd_valid_nxt = ent_v[io_RADD] && !io_CLR;
    if (bypass) begin
      rd_data_nxt  = io_WDATA;
      rd_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_RDATA  <= '0;
      io_RVALID <= 1'b0;
      io_ERR    <= 1'b0;
    end else begin
      io_RDATA  <= rd_data_nxt;
      io_RVALID <= rd_valid_nxt;
      if (wr_illegal)  io_ERR <= 1'b1;
      else if (io_CLR) io_ERR <= 1'b0;
    end
  end

endmodule
